// File: rtl/mips_disp_pkg.sv
// Shared types and constants for the post-run result display path.
// Holds the walker FSM state enum, data width and default timings.
package mips_disp_pkg;

   localparam int DATA_W              = 32;
   localparam int DEF_DWELL_CYCLES    = 100_000_000;
   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WAIT,
      SHOW
   } walk_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop sync, stable-level counter, rise pulse.
// Ports: clk, rst (async high), btn (raw), step_p (1-cycle accepted 0->1).
module btn_debounce
   import mips_disp_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic step_p
);

   localparam int CW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic          level;
   logic          stable;
   logic [CW-1:0] cnt;

   // level tracks the last sampled value; stable is the accepted one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         level  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
         step_p <= 1'b0;
      end else begin
         s1     <= btn;
         s2     <= s1;
         step_p <= 1'b0;
         if (s2 != level) begin
            level <= s2;
            cnt   <= '0;
         end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CW'(1);
         end else begin
            stable <= level;
            step_p <= level & ~stable;
         end
      end
   end

endmodule

// File: rtl/dmem_result_walker.sv
// Walks a window of dmem words after the CPU is done, one per display.
// Ports: clk, rst, cpu_done, step_btn, auto_en, mem_* read port, disp_*.
module dmem_result_walker
   import mips_disp_pkg::*;
#(
   parameter int ADDR_W          = 11,
   parameter int BASE_ADDR       = 0,
   parameter int NUM_WORDS       = 8,
   parameter int DWELL_CYCLES    = DEF_DWELL_CYCLES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_done,
   input  logic              step_btn,
   input  logic              auto_en,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   output logic [3:0]        disp_index
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [3:0] IDX_LAST = 4'(NUM_WORDS - 1);
   localparam int DWW =
      (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL_CYCLES - 1);

   walk_state_t    state;
   walk_state_t    state_nx;
   logic           done_m;
   logic           done_s;
   logic           step_p;
   logic           tick_p;
   logic           advance;
   logic [3:0]     idx_nx;
   logic [DWW-1:0] dwell;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk   (clk),
      .rst   (rst),
      .btn   (step_btn),
      .step_p(step_p)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_m <= 1'b0;
         done_s <= 1'b0;
      end else begin
         done_m <= cpu_done;
         done_s <= done_m;
      end
   end

   assign tick_p = (state == SHOW) && auto_en && (dwell == DWELL_LAST);

   always_comb begin
      state_nx = state;
      idx_nx   = disp_index;
      advance  = 1'b0;
      if (!done_s) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               state_nx = READ;
               idx_nx   = '0;
            end
            READ: state_nx = WAIT;
            WAIT: state_nx = SHOW;
            SHOW: begin
               if (step_p || tick_p) begin
                  advance  = 1'b1;
                  state_nx = READ;
                  idx_nx   = (disp_index == IDX_LAST) ?
                             4'd0 : disp_index + 4'd1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so that the strobe,
   // address and index all land on the cycle READ is entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mem_rd_en  <= 1'b0;
         mem_addr   <= BASE;
         disp_index <= '0;
         disp_data  <= '0;
         disp_valid <= 1'b0;
         dwell      <= '0;
      end else begin
         state      <= state_nx;
         mem_rd_en  <= (state_nx == READ);
         mem_addr   <= BASE + ADDR_W'(idx_nx);
         disp_index <= idx_nx;
         if ((state == WAIT) && done_s) begin
            disp_data  <= mem_rdata;
            disp_valid <= 1'b1;
         end else if (state_nx == IDLE) begin
            disp_valid <= 1'b0;
         end
         if ((state != SHOW) || advance) begin
            dwell <= '0;
         end else if (auto_en) begin
            dwell <= dwell + DWW'(1);
         end
      end
   end

endmodule

// File: tb/tb_dmem_result_walker.sv
// Self-checking bench for dmem_result_walker with a 1-cycle dmem model.
// Window of 4 words at 0x10, dwell 20, debounce 4.
module tb_dmem_result_walker;

   localparam int AW    = 11;
   localparam int BASE  = 16;
   localparam int NW    = 4;
   localparam int DWELL = 20;
   localparam int DEB   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_done;
   logic          step_btn;
   logic          auto_en;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_rdata;
   logic [31:0]   disp_data;
   logic          disp_valid;
   logic [3:0]    disp_index;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int exp_idx = 0;

   logic [AW-1:0] rd_addr_q[$];
   int            rd_cyc_q[$];

   dmem_result_walker #(
      .ADDR_W         (AW),
      .BASE_ADDR      (BASE),
      .NUM_WORDS      (NW),
      .DWELL_CYCLES   (DWELL),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_done  (cpu_done),
      .step_btn  (step_btn),
      .auto_en   (auto_en),
      .mem_rd_en (mem_rd_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .disp_data (disp_data),
      .disp_valid(disp_valid),
      .disp_index(disp_index)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= 32'hA0 + 32'(mem_addr);
      else           mem_rdata <= 32'hDEAD_BEEF;
   end

   always @(negedge clk) begin
      if (mem_rd_en) begin
         rd_addr_q.push_back(mem_addr);
         rd_cyc_q.push_back(cyc);
      end
   end

   function automatic logic [31:0] word_at(input int i);
      return 32'(32'hA0 + BASE + i);
   endfunction

   function automatic int next_idx(input int i);
      return (i + 1) % NW;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_q();
      rd_addr_q.delete();
      rd_cyc_q.delete();
   endtask

   task automatic wait_read(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc && !ok; i++) begin
         tick();
         if (rd_cyc_q.size() != 0) ok = 1'b1;
      end
   endtask

   task automatic press(input int n);
      step_btn = 1'b1;
      repeat (n) tick();
      step_btn = 1'b0;
      repeat (15) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cpu_done = 1'b0;
      step_btn = 1'b0;
      auto_en = 1'b0;
      repeat (3) tick();
      n_chk++;
      if (mem_rd_en !== 1'b0 || disp_valid !== 1'b0 ||
          disp_data !== 32'h0 || disp_index !== 4'd0 ||
          mem_addr !== AW'(BASE)) begin
         n_fail++;
         $display("FAIL reset_vals rd=%b v=%b d=%h i=%0d a=%h req 0 0 0 0 %h",
                  mem_rd_en, disp_valid, disp_data, disp_index,
                  mem_addr, AW'(BASE));
      end
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         n_chk++;
         if (mem_rd_en !== 1'b0 || disp_valid !== 1'b0 ||
             disp_data !== 32'h0 || disp_index !== 4'd0 ||
             mem_addr !== AW'(BASE)) begin
            n_fail++;
            $display("FAIL idle_hold cyc=%0d rd=%b v=%b d=%h i=%0d a=%h",
                     cyc, mem_rd_en, disp_valid, disp_data,
                     disp_index, mem_addr);
         end
      end
   endtask

   task automatic start_check(input string tag);
      int c0;
      clear_q();
      c0 = cyc;
      cpu_done = 1'b1;
      exp_idx = 0;
      repeat (4) tick();
      n_chk++;
      if (rd_cyc_q.size() != 1) begin
         n_fail++;
         $display("FAIL %s_rd_count got %0d req 1", tag, rd_cyc_q.size());
      end else begin
         n_chk++;
         if (rd_cyc_q[0] != c0 + 3 || rd_addr_q[0] !== AW'(BASE)) begin
            n_fail++;
            $display("FAIL %s_rd got cyc+%0d addr %h req cyc+3 addr %h",
                     tag, rd_cyc_q[0] - c0, rd_addr_q[0], AW'(BASE));
         end
      end
      n_chk++;
      if (disp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_early_valid got %b req 0", tag, disp_valid);
      end
      tick();
      n_chk++;
      if (disp_valid !== 1'b1 || disp_data !== word_at(0) ||
          disp_index !== 4'd0) begin
         n_fail++;
         $display("FAIL %s_show got v=%b d=%h i=%0d req 1 %h 0",
                  tag, disp_valid, disp_data, disp_index, word_at(0));
      end
   endtask

   task automatic test_first_read();
      start_check("start");
      repeat (40) tick();
      n_chk++;
      if (rd_cyc_q.size() != 1) begin
         n_fail++;
         $display("FAIL no_auto_reads got %0d reads req 1",
                  rd_cyc_q.size());
      end
   endtask

   task automatic check_adv(input string tag);
      exp_idx = next_idx(exp_idx);
      n_chk++;
      if (rd_cyc_q.size() != 1) begin
         n_fail++;
         $display("FAIL %s_reads got %0d req 1", tag, rd_cyc_q.size());
      end else begin
         n_chk++;
         if (rd_addr_q[0] !== AW'(BASE + exp_idx)) begin
            n_fail++;
            $display("FAIL %s_addr got %h req %h",
                     tag, rd_addr_q[0], AW'(BASE + exp_idx));
         end
      end
      n_chk++;
      if (disp_valid !== 1'b1 || disp_data !== word_at(exp_idx) ||
          disp_index !== 4'(exp_idx)) begin
         n_fail++;
         $display("FAIL %s_show got v=%b d=%h i=%0d req 1 %h %0d",
                  tag, disp_valid, disp_data, disp_index,
                  word_at(exp_idx), exp_idx);
      end
   endtask

   task automatic test_step_press();
      for (int k = 0; k < 4; k++) begin
         clear_q();
         press(10);
         check_adv("press");
      end
   endtask

   task automatic test_bounce();
      clear_q();
      for (int i = 0; i < 12; i++) begin
         step_btn = ((i / 2) % 2) == 0;
         tick();
      end
      press(10);
      check_adv("bounce");
   endtask

   task automatic test_auto_align();
      int a;
      int e;
      bit ok;
      logic [31:0] old_w;
      clear_q();
      a = cyc;
      auto_en = 1'b1;
      wait_read(30, ok);
      n_chk++;
      if (!ok || rd_cyc_q[0] != a + DWELL) begin
         n_fail++;
         $display("FAIL auto_first got ok=%0d cyc+%0d req cyc+%0d",
                  ok, ok ? rd_cyc_q[0] - a : -1, DWELL);
      end
      if (!ok) return;
      e = rd_cyc_q[0] + 2;
      while (cyc < e) tick();
      check_adv("auto1");
      clear_q();
      old_w = word_at(exp_idx);
      while (cyc < e + 12) tick();
      step_btn = 1'b1;
      while (cyc < e + 22) begin
         tick();
         if (cyc == e + 21) begin
            n_chk++;
            if (disp_valid !== 1'b1 || disp_data !== old_w) begin
               n_fail++;
               $display("FAIL refetch_hold got v=%b d=%h req 1 %h",
                        disp_valid, disp_data, old_w);
            end
         end
      end
      step_btn = 1'b0;
      n_chk++;
      if (rd_cyc_q.size() != 1 || rd_cyc_q[0] != e + DWELL) begin
         n_fail++;
         $display("FAIL align_once got %0d reads first cyc+%0d req 1 at +%0d",
                  rd_cyc_q.size(),
                  rd_cyc_q.size() != 0 ? rd_cyc_q[0] - e : -1, DWELL);
      end
      check_adv("align");
      clear_q();
      wait_read(40, ok);
      auto_en = 1'b0;
      n_chk++;
      if (!ok || rd_cyc_q[0] != e + 2 * DWELL + 2) begin
         n_fail++;
         $display("FAIL auto_next got ok=%0d cyc+%0d req cyc+%0d",
                  ok, ok ? rd_cyc_q[0] - e : -1, 2 * DWELL + 2);
      end
      repeat (2) tick();
      check_adv("auto2");
      clear_q();
      repeat (40) tick();
      n_chk++;
      if (rd_cyc_q.size() != 0) begin
         n_fail++;
         $display("FAIL auto_off got %0d reads req 0", rd_cyc_q.size());
      end
   endtask

   task automatic test_done_drop();
      int d;
      for (int k = 0; k < NW && exp_idx != 2; k++) begin
         clear_q();
         press(10);
         check_adv("seek");
      end
      d = cyc;
      cpu_done = 1'b0;
      repeat (2) tick();
      n_chk++;
      if (disp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_early got v=%b req 1", disp_valid);
      end
      tick();
      n_chk++;
      if (cyc != d + 3 || disp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_clear got v=%b req 0", disp_valid);
      end
      repeat (10) tick();
      start_check("restart");
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_first_read();
      test_step_press();
      test_bounce();
      test_auto_align();
      test_done_drop();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
